// File: rtl/dsc_unary_stream_gen.sv
// Deterministic unary (thermometer) bitstream generator: latches NUM_INPUTS operands and streams
// one unary bit per operand per transfer. Optional feature macro: DSC_STREAM_EARLY_STOP_EN.
module dsc_unary_stream_gen #(
    parameter int unsigned DATA_WIDTH = 5,
    parameter int unsigned NUM_INPUTS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] bin_data_in [NUM_INPUTS-1:0],
    input  logic                  stream_ready,
    output logic [NUM_INPUTS-1:0] stream_out,
    output logic                  stream_valid,
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned CNT_W = DATA_WIDTH * NUM_INPUTS;
    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] op_q [NUM_INPUTS-1:0];
    logic [DATA_WIDTH-1:0] op_d [NUM_INPUTS-1:0];
    logic [NUM_INPUTS-1:0] stream_out_q, stream_out_d;
    logic                  stream_valid_q, stream_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

`ifdef DSC_STREAM_EARLY_STOP_EN
    logic any_zero;

    always_comb begin
        any_zero = 1'b0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (bin_data_in[i] == '0) any_zero = 1'b1;
        end
    end
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        stream_valid_d = stream_valid_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    op_d  = bin_data_in;
                    cnt_d = '0;
`ifdef DSC_STREAM_EARLY_STOP_EN
                    if (any_zero) begin
                        state_d = FINISH;
                        busy_d  = 1'b1;
                    end else begin
                        state_d        = STREAM;
                        stream_valid_d = 1'b1;
                        busy_d         = 1'b1;
                    end
`else
                    state_d        = STREAM;
                    stream_valid_d = 1'b1;
                    busy_d         = 1'b1;
`endif
                end
            end
            STREAM: begin
                if (stream_valid_q && stream_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d        = FINISH;
                        stream_valid_d = 1'b0;
                        busy_d         = 1'b0;
                        done_d         = 1'b1;
                    end
                end
            end
            FINISH: begin
                // Entry without a pending done (early stop) spends one extra FINISH cycle to pulse it.
                if (!done_q) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so the bits are derived from the next counter and operands.
        stream_out_d = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            stream_out_d[i] = stream_valid_d && (cnt_d[i*DATA_WIDTH +: DATA_WIDTH] < op_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            op_q           <= '{default: '0};
            stream_out_q   <= '0;
            stream_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            stream_out_q   <= stream_out_d;
            stream_valid_q <= stream_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign stream_out   = stream_out_q;
    assign stream_valid = stream_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
